mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit that consumes the EX/MEM pipeline register outputs and runs a
//  multi-cycle req/ready transaction on the data-memory bus. Produces byte-lane enables, store-data
//  replication and load extraction with sign/zero extension. Drives Stall, which the hazard logic
//  uses to hold Ld low on all upstream pipeline registers until the access completes.
// PARAMETERS
//  ADDR_W   32   data-memory byte-address width
//  TIMEOUT  255  ACCESS cycles without mem_ready before a bus error is declared (1..2^TO_W-1)
//  TO_W     8    timeout counter width
// PORTS
//  Clk            in   1       clock, rising edge
//  Clr            in   1       asynchronous, active-low reset
//  MEM_MemRead    in   1       load request from the EX/MEM register
//  MEM_MemWrite   in   1       store request from the EX/MEM register
//  MEM_Datatype   in   2       00 word, 01 half, 10 byte, 11 treated as word
//  MEM_LdUnsigned in   1       1 = zero-extend loads, 0 = sign-extend loads
//  MEM_ALUResult  in   ADDR_W  effective byte address
//  MEM_Data2      in   32      store data (right-justified)
//  mem_req        out  1       bus request; high for the whole ACCESS state
//  mem_we         out  1       1 = write, 0 = read
//  mem_addr       out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  mem_be         out  4       byte-lane enables, little-endian
//  mem_wdata      out  32      lane-replicated store data
//  mem_ready      in   1       bus completes the transfer this cycle
//  mem_rdata      in   32      read data, valid when mem_ready=1
//  Stall          out  1       hold upstream pipeline registers
//  ReadData       out  32      extended load result
//  ReadValid      out  1       one-cycle pulse; ReadData valid (loads only)
//  Misaligned     out  1       one-cycle pulse; misaligned access rejected
//  BusErr         out  1       one-cycle pulse; timeout expired
// BEHAVIOUR
//  Reset (Clr=0, async): state IDLE, counter 0, latched op cleared. mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata, ReadData, ReadValid, Misaligned and BusErr are all 0. Stall is 0 while
//   Clr=0. Reset mid-ACCESS drops mem_req immediately and abandons the transfer.
//  op = MEM_MemRead|MEM_MemWrite. If both are set, the access is a write.
//  Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
//  FSM:
//   IDLE  : if op and aligned, latch addr/data/type/we/unsigned, counter=0, go to ACCESS.
//           If op and misaligned, go to DONE with Misaligned pulse; no bus access.
//   ACCESS: mem_req=1 and bus outputs come from the latched op.
//           mem_ready=1 -> DONE; for a read, capture extract(mem_rdata).
//           Otherwise counter++. When counter reaches TIMEOUT-1 with no ready -> DONE,
//           BusErr pulse, ReadData=0.
//   DONE  : one cycle. ReadValid=1 for a successful read. Go to IDLE.
//  Stall = (IDLE & op) | ACCESS. Combinational. Low in DONE, so EX/MEM advances at the end of DONE.
//  mem_ready outside ACCESS is ignored.
//  mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
//  mem_wdata: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
//  extract: shift mem_rdata right by 8*addr[1:0], keep 8/16/32 bits, extend per LdUnsigned.
//  ReadData holds its value until the next successful read or error.
//  Misaligned and BusErr pulses are registered and coincide with the DONE cycle.
//  Latency: aligned access with ready on the first ACCESS cycle = 2 stall cycles, then 1 DONE cycle.
// TESTING
//  1. LB addr=0x13, mem_rdata=0x80FF_1234, ready in 1st ACCESS -> be=1000, ReadData=0xFFFF_FF80,
//     ReadValid in cycle 2.
//  2. SH addr=0x22, Data2=0x0000_BEEF -> mem_we=1, be=1100, wdata=0xBEEF_BEEF, Stall for 2 cycles.
//  3. LW addr=0x06 -> no mem_req, Misaligned pulse, Stall for 1 cycle, ReadValid=0.
//  4. LW, mem_ready held 0, TIMEOUT=4 -> mem_req for 4 cycles, BusErr pulse, ReadData=0, back to IDLE.
//  5. LHU addr=0x02, ready after 3 wait cycles, rdata=0x9ABC_0000 -> ReadData=0x0000_9ABC,
//     Stall for 5 cycles.
//  6. Clr=0 during ACCESS -> mem_req and Stall drop 0 asynchronously; after release, state IDLE
//     and a new LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the memory (slave).
//   mem_req   : request, held for the whole transfer
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_be    : little-endian byte-lane enables
//   mem_wdata : lane-replicated store data
//   mem_ready : memory completes the transfer this cycle
//   mem_rdata : read data, valid with mem_ready
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Takes the EX/MEM register outputs, runs one
// req/ready transfer on the data-memory bus and returns the extended load
// result. Stall holds the upstream pipeline registers until the access is done.
//   Clk, Clr            : clock (rising edge), asynchronous active-low reset
//   MEM_MemRead/Write   : load / store request (both set = store)
//   MEM_Datatype        : 00 word, 01 half, 10 byte, 11 word
//   MEM_LdUnsigned      : 1 = zero-extend loads
//   MEM_ALUResult       : effective byte address
//   MEM_Data2           : right-justified store data
//   bus                 : data-memory bus (master side)
//   Stall               : hold upstream registers (combinational)
//   ReadData/ReadValid  : load result and its one-cycle valid pulse
//   Misaligned, BusErr  : one-cycle error pulses in the DONE cycle
module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [1:0]        MEM_Datatype,
  input  logic              MEM_LdUnsigned,
  input  logic [ADDR_W-1:0] MEM_ALUResult,
  input  logic [31:0]       MEM_Data2,
  mem_stage_lsu_if.master   bus,
  output logic              Stall,
  output logic [31:0]       ReadData,
  output logic              ReadValid,
  output logic              Misaligned,
  output logic              BusErr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      lat_off;
  logic [1:0]      lat_dt;
  logic            lat_uns;

  logic        op;
  logic        aligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign op = MEM_MemRead | MEM_MemWrite;

  // Request decode from the live EX/MEM fields; registered into the bus on entry to ACCESS.
  always_comb begin
    aligned = 1'b1;
    be_n    = 4'b1111;
    wdata_n = MEM_Data2;
    unique case (MEM_Datatype)
      2'b10: begin
        be_n    = 4'b0001 << MEM_ALUResult[1:0];
        wdata_n = {4{MEM_Data2[7:0]}};
      end
      2'b01: begin
        aligned = ~MEM_ALUResult[0];
        be_n    = 4'b0011 << MEM_ALUResult[1:0];
        wdata_n = {2{MEM_Data2[15:0]}};
      end
      default: aligned = (MEM_ALUResult[1:0] == 2'b00);
    endcase
  end

  // Load extraction uses the latched offset/type so it does not depend on EX/MEM during ACCESS.
  always_comb begin
    shifted = bus.mem_rdata >> {lat_off, 3'b000};
    unique case (lat_dt)
      2'b10:   ext = lat_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = lat_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Clr gates Stall so it is low throughout reset even with a request pending.
  assign Stall = Clr & (((state == IDLE) & op) | (state == ACCESS));

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_off       <= '0;
      lat_dt        <= '0;
      lat_uns       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      ReadData      <= '0;
      ReadValid     <= 1'b0;
      Misaligned    <= 1'b0;
      BusErr        <= 1'b0;
    end else begin
      ReadValid  <= 1'b0;
      Misaligned <= 1'b0;
      BusErr     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op && aligned) begin
            state         <= ACCESS;
            cnt           <= '0;
            lat_off       <= MEM_ALUResult[1:0];
            lat_dt        <= MEM_Datatype;
            lat_uns       <= MEM_LdUnsigned;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= MEM_MemWrite;
            bus.mem_addr  <= {MEM_ALUResult[ADDR_W-1:2], 2'b00};
            bus.mem_be    <= be_n;
            bus.mem_wdata <= wdata_n;
          end else if (op) begin
            state      <= DONE;
            Misaligned <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus.mem_ready || cnt == TO_W'(TIMEOUT - 1)) begin
            state         <= DONE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            if (bus.mem_ready) begin
              if (!bus.mem_we) begin
                ReadData  <= ext;
                ReadValid <= 1'b1;
              end
            end else begin
              BusErr   <= 1'b1;
              ReadData <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 4;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        MEM_MemRead, MEM_MemWrite, MEM_LdUnsigned;
  logic [1:0]  MEM_Datatype;
  logic [31:0] MEM_ALUResult, MEM_Data2;
  logic        Stall, ReadValid, Misaligned, BusErr;
  logic [31:0] ReadData;

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .Clk(Clk), .Clr(Clr),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_Datatype(MEM_Datatype), .MEM_LdUnsigned(MEM_LdUnsigned),
    .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
    .bus(bus.master),
    .Stall(Stall), .ReadData(ReadData), .ReadValid(ReadValid),
    .Misaligned(Misaligned), .BusErr(BusErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        mis;
    logic        berr;
    logic        rv;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Datatype = 2'b00;
    MEM_LdUnsigned = 1'b0; MEM_ALUResult = '0; MEM_Data2 = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  // delay = number of ACCESS wait cycles before mem_ready; >= TIMEOUT means never ready.
  task automatic run_op(input string name, input logic rd, input logic wr, input logic [1:0] dt,
                        input logic uns, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdat, input int delay);
    exp_t        e, g;
    logic [31:0] sh, ext;
    logic        isb, ish, to;
    int          stalls, acc, cyc;
    bit          seen;
    isb = (dt == 2'b10);
    ish = (dt == 2'b01);
    e.mis   = ish ? addr[0] : (isb ? 1'b0 : (addr[1:0] != 2'b00));
    to      = !e.mis && (delay >= TIMEOUT);
    e.berr  = to;
    e.we    = wr;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = isb ? (4'b0001 << addr[1:0]) : ish ? (4'b0011 << addr[1:0]) : 4'b1111;
    e.wdata = isb ? {4{data[7:0]}} : ish ? {2{data[15:0]}} : data;
    sh      = rdat >> (8 * addr[1:0]);
    ext     = isb ? (uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]}) :
              ish ? (uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : sh;
    e.rv    = !e.mis && !to && !wr;
    if (e.rv) exp_rd = ext;
    else if (to) exp_rd = '0;
    e.rdata  = exp_rd;
    e.acc    = e.mis ? 0 : (to ? TIMEOUT : delay + 1);
    e.stalls = 1 + e.acc;
    sb.push_back(e);

    @(negedge Clk);
    MEM_MemRead = rd; MEM_MemWrite = wr; MEM_Datatype = dt;
    MEM_LdUnsigned = uns; MEM_ALUResult = addr; MEM_Data2 = data;
    #1;
    stalls = 0; acc = 0; seen = 0; cyc = 0;
    while (Stall && cyc < 40) begin
      stalls++;
      cyc++;
      if (bus.mem_req) begin
        if (!seen) begin
          seen = 1;
          g = sb[0];
          chk({name, " we"},    32'(bus.mem_we), 32'(g.we));
          chk({name, " be"},    32'(bus.mem_be), 32'(g.be));
          chk({name, " addr"},  bus.mem_addr, g.addr);
          if (g.we) chk({name, " wdata"}, bus.mem_wdata, g.wdata);
        end
        bus.mem_ready = (acc == delay);
        bus.mem_rdata = rdat;
        acc++;
      end
      @(posedge Clk);
      #1 bus.mem_ready = 1'b0;
      @(negedge Clk);
      #1;
    end
    if (cyc >= 40) chk({name, " done timeout"}, 32'(cyc), 32'(0));

    // DONE cycle: compare against the oldest expectation.
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({name, " stalls"},     32'(stalls),     32'(e.stalls));
      chk({name, " acc"},        32'(acc),        32'(e.acc));
      chk({name, " req_done"},   32'(bus.mem_req), 32'(0));
      chk({name, " ReadValid"},  32'(ReadValid),  32'(e.rv));
      chk({name, " Misaligned"}, 32'(Misaligned), 32'(e.mis));
      chk({name, " BusErr"},     32'(BusErr),     32'(e.berr));
      chk({name, " ReadData"},   ReadData,        e.rdata);
    end
    idle_inputs();
    @(negedge Clk);
    #1 chk({name, " pulses_clear"}, {29'b0, ReadValid, Misaligned, BusErr}, 32'(0));
  endtask

  initial begin
    idle_inputs();
    Clr = 1'b0;
    // Request present during reset: Stall must still be low.
    MEM_MemRead = 1'b1; MEM_ALUResult = 32'h40;
    #12;
    chk("rst Stall",    32'(Stall),        32'(0));
    chk("rst mem_req",  32'(bus.mem_req),  32'(0));
    chk("rst mem_be",   32'(bus.mem_be),   32'(0));
    chk("rst mem_addr", bus.mem_addr,      32'(0));
    chk("rst ReadData", ReadData,          32'(0));
    chk("rst pulses",   {29'b0, ReadValid, Misaligned, BusErr}, 32'(0));
    idle_inputs();
    @(negedge Clk) Clr = 1'b1;

    run_op("LB",        1, 0, 2'b10, 0, 32'h13, 32'h0,        32'h80FF_1234, 0);
    run_op("SH",        0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h0,        0);
    run_op("LW_mis",    1, 0, 2'b00, 0, 32'h06, 32'h0,        32'h0,         0);
    run_op("LW_to",     1, 0, 2'b00, 0, 32'h08, 32'h0,        32'hDEAD_BEEF, 99);
    run_op("LHU",       1, 0, 2'b01, 1, 32'h02, 32'h0,        32'h9ABC_0000, 3);
    run_op("SB",        0, 1, 2'b10, 0, 32'h01, 32'h1234_5678, 32'h0,        1);
    run_op("LH",        1, 0, 2'b01, 0, 32'h06, 32'h0,        32'h8001_0000, 0);
    run_op("LBU",       1, 0, 2'b10, 1, 32'h10, 32'h0,        32'h0000_00F0, 2);
    run_op("RW_both",   1, 1, 2'b11, 0, 32'h1C, 32'hCAFE_F00D, 32'h0,        0);
    run_op("LH_mis",    1, 0, 2'b01, 0, 32'h03, 32'h0,        32'h0,         0);
    run_op("SW_to",     0, 1, 2'b00, 0, 32'h30, 32'h1111_2222, 32'h0,        99);
    run_op("LW_edge",   1, 0, 2'b11, 0, 32'h24, 32'h0,        32'h5566_7788, TIMEOUT - 1);

    // Reset in the middle of an access.
    @(negedge Clk);
    MEM_MemRead = 1'b1; MEM_ALUResult = 32'h40;
    repeat (3) @(negedge Clk);
    #1 chk("mid req_before", 32'(bus.mem_req), 32'(1));
    #2 Clr = 1'b0;
    #1;
    chk("mid req_async",   32'(bus.mem_req), 32'(0));
    chk("mid stall_async", 32'(Stall),       32'(0));
    chk("mid ReadData",    ReadData,         32'(0));
    exp_rd = '0;
    idle_inputs();
    @(negedge Clk) Clr = 1'b1;
    @(negedge Clk);
    #1 chk("post_rst idle", {29'b0, Stall, bus.mem_req, ReadValid}, 32'(0));
    run_op("LW_post",   1, 0, 2'b00, 0, 32'h44, 32'h0,        32'h0BAD_F00D, 1);

    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
